// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - read/write/clear port bundle for regfile_param
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] WriteRegister;
  logic              RegWrite;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              ClearReq;
  logic              Busy;
  logic              WriteDropped;

  modport master (
    output WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2, ClearReq,
    input  ReadData1, ReadData2, Busy, WriteDropped
  );

  modport slave (
    input  WriteData, WriteRegister, RegWrite, ReadRegister1, ReadRegister2, ClearReq,
    output ReadData1, ReadData2, Busy, WriteDropped
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R1W register file with multi-cycle clear sweep
// Optional same-cycle write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic            clk,
  input logic            reset_n,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] sweepAddr;
  logic              busy;
  logic              writeDropped;
  logic              writeAllowed;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Entry 0 is never stored to when hardwired, so it stays at its reset zero.
  assign writeAllowed = !((ZERO_REG != 0) && (bus.WriteRegister == '0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      state        <= IDLE;
      sweepAddr    <= '0;
      busy         <= 1'b0;
      writeDropped <= 1'b0;
    end else begin
      writeDropped <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.RegWrite && writeAllowed) begin
            regs[bus.WriteRegister] <= bus.WriteData;
          end
          if (bus.ClearReq) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            sweepAddr <= FIRST_ADDR;
          end
        end
        SWEEP: begin
          writeDropped    <= bus.RegWrite;
          regs[sweepAddr] <= '0;
          // Stop on compare rather than letting the counter wrap.
          if (sweepAddr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sweepAddr <= sweepAddr + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd1 = regs[bus.ReadRegister1];
    rd2 = regs[bus.ReadRegister2];
    if ((ZERO_REG != 0) && (bus.ReadRegister1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (bus.ReadRegister2 == '0)) rd2 = '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite && !busy && writeAllowed && (bus.ReadRegister1 == bus.WriteRegister)) begin
      rd1 = bus.WriteData;
    end
    if (bus.RegWrite && !busy && writeAllowed && (bus.ReadRegister2 == bus.WriteRegister)) begin
      rd2 = bus.WriteData;
    end
`else
`endif
  end

  assign bus.ReadData1    = rd1;
  assign bus.ReadData2    = rd2;
  assign bus.Busy         = busy;
  assign bus.WriteDropped = writeDropped;
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file.
- Width, depth and hardwired-zero behaviour are generics.
- Adds a multi-cycle clear sweep FSM with a busy flag and dropped-write reporting.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port); reads stay combinational, writes stay clocked.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero and unwritable; when 0 entry 0 is an ordinary register.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- WriteData  in  DATA_W  data to write.
- WriteRegister  in  ADDR_W  write address.
- RegWrite  in  1  write enable.
- ReadRegister1  in  ADDR_W  read address, port 1.
- ReadRegister2  in  ADDR_W  read address, port 2.
- ReadData1  out  DATA_W  read data, port 1 (combinational).
- ReadData2  out  DATA_W  read data, port 2 (combinational).
- ClearReq  in  1  request to zero all entries by sweep.
- Busy  out  1  high while a clear sweep is in progress.
- WriteDropped  out  1  registered one-cycle pulse: a write was refused.

Behaviour:
- Clock is clk; reset is synchronous and active-low on reset_n (already decided).
- Reset (reset_n=0 at a rising edge):
  - all entries become 0; FSM goes to IDLE; Busy=0; WriteDropped=0.
  - reset has priority over everything, including mid-sweep (sweep aborts, all entries 0).
- Reads:
  - ReadDataN = entry[ReadRegisterN], combinational, zero-cycle latency.
  - With ZERO_REG=1, address 0 always reads 0.
  - Both ports may address the same entry.
- Writes:
  - In IDLE with RegWrite=1, entry[WriteRegister] <= WriteData at the rising edge; visible on reads from the next cycle.
  - With ZERO_REG=1, a write to address 0 is silently ignored; it is not a drop.
  - When Busy=1 and RegWrite=1, the write is discarded and WriteDropped=1 in the following cycle only.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP: ClearReq=1 at a rising edge. Busy=1 from the next cycle. Sweep counter loads the first sweepable address (1 if ZERO_REG else 0).
  - Same-edge ClearReq with RegWrite in IDLE: the write is performed; the sweep then clears it in due course.
  - SWEEP: each cycle entry[counter] <= 0, then counter increments.
  - SWEEP -> IDLE: on the edge that clears address DEPTH-1; Busy=0 from the next cycle.
  - Sweep length is DEPTH-1 cycles (ZERO_REG=1) or DEPTH cycles (ZERO_REG=0).
  - ClearReq while in SWEEP is ignored and does not restart the sweep.
- Reads during SWEEP return current contents: already-swept entries read 0, unswept entries read their old values.
- Counter is ADDR_W bits wide; termination is by compare to DEPTH-1, never by overflow wrap.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - if RegWrite=1, Busy=0, the write is not to hardwired entry 0, and ReadRegisterN==WriteRegister, then ReadDataN = WriteData in the same cycle (write-through forwarding).
  - forwarding applies independently to both read ports.
- Not defined: a read in the write cycle returns the old contents; the new value appears the next cycle.

Test Plan:
- Reset, then RegWrite=1, WriteRegister=0, WriteData=32'hA0; read addr 0 -> ReadData1=0 with ZERO_REG=1, WriteDropped=0.
- Write i*32'h01020408 to each addr 1..31 in turn, then read pairs (i-1, i) -> each port returns its stored value; without bypass, the same-cycle read of addr i returns the old value.
- Write 32'hDEADBEEF to addr 7, pulse ClearReq -> Busy high for 31 cycles; addr 7 reads 0 after cycle 7 of the sweep; addr 31 keeps its value until the final sweep cycle; Busy=0 afterwards.
- During SWEEP, RegWrite=1 to addr 3 with 32'h1234 -> WriteDropped=1 for exactly one cycle, addr 3 stays 0; ClearReq asserted mid-sweep -> total Busy duration unchanged.
- Assert reset_n=0 for one edge at sweep cycle 10 -> Busy=0 next cycle, all 31 entries read 0, FSM idle, new writes accepted.
- With REGFILE_BYPASS_EN defined: write 32'hCAFEF00D to addr 5 with ReadRegister1=ReadRegister2=5 -> both ports show 32'hCAFEF00D in that same cycle; write to addr 0 -> reads stay 0.
